alu_issue_ctrl: RTL and testbench

Request/response front end that sits directly upstream of the 16-bit clocked `alu`. It accepts one operation at a time over a valid/ready request channel, registers and drives the ALU's `in1`/`in2`/`alu_op`, and waits the ALU's fixed latency. It then captures `alu_out` and `z` into a response register held under a valid/ready response channel. It also rejects illegal opcodes without issuing them and keeps a completed-operation count.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_lat_counter.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit clocked ALU and the logic that feeds it.
// Holds the datapath widths, the opcode map, the highest legal opcode and the
// issue-controller FSM state encoding.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 3'd3;
    // Highest legal opcode; any larger opcode is rejected with an error response.
    localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = ALU_OP_OR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_lat_counter.sv
// Latency counter for the ALU issue controller.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear_i    - synchronous clear to zero (wins over en_i)
//   en_i       - increment by one this cycle
//   hit_o      - count equals ALU_LAT
module alu_lat_counter #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == 3'(ALU_LAT));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Request/response front end for the clocked ALU. Accepts one op at a time,
// drives the ALU inputs from registers, waits ALU_LAT edges, then holds the
// captured result until the consumer takes it. Illegal opcodes are answered
// with resp_err without touching the ALU. done_count counts handshakes.
// Ports:
//   clock, reset_n                  - clock, asynchronous active-low reset
//   req_valid/req_ready, req_op/a/b - request channel
//   resp_valid/resp_ready           - response channel
//   resp_data, resp_z, resp_err     - captured ALU result / flags / illegal-op
//   alu_in1, alu_in2, alu_op_o      - registered ALU operands and opcode
//   alu_result, alu_z               - ALU outputs
//   done_count                      - completed response handshakes (wraps)
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        resp_z,
    output logic              resp_err,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [1:0]        alu_z,
    output logic [15:0]       done_count
);

    issue_state_e      state_q, state_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [1:0]        resp_z_q, resp_z_d;
    logic              resp_err_q, resp_err_d;
    logic [15:0]       done_q, done_d;

    logic op_legal;
    logic accept_legal;
    logic lat_hit;

    assign op_legal     = (req_op <= OP_W'(ALU_OP_LAST));
    assign accept_legal = (state_q == ST_IDLE) && req_valid && op_legal;

    // Counter starts at zero in the first WAIT cycle; hit marks the cycle in
    // which alu_result already reflects the issued operands.
    alu_lat_counter #(
        .ALU_LAT (ALU_LAT)
    ) u_lat_counter (
        .clk     (clock),
        .rst_n   (reset_n),
        .clear_i (accept_legal),
        .en_i    (state_q == ST_WAIT),
        .hit_o   (lat_hit)
    );

    always_comb begin
        state_d     = state_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        op_d        = op_q;
        resp_data_d = resp_data_q;
        resp_z_d    = resp_z_q;
        resp_err_d  = resp_err_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (op_legal) begin
                        in1_d   = req_a;
                        in2_d   = req_b;
                        op_d    = req_op;
                        state_d = ST_WAIT;
                    end else begin
                        // Answered locally; the ALU keeps its previous operands.
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        resp_z_d    = '0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_hit) begin
                    resp_data_d = alu_result;
                    resp_z_d    = alu_z;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            resp_data_q <= '0;
            resp_z_q    <= '0;
            resp_err_q  <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            op_q        <= op_d;
            resp_data_q <= resp_data_d;
            resp_z_q    <= resp_z_d;
            resp_err_q  <= resp_err_d;
            done_q      <= done_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_z     = resp_z_q;
    assign resp_err   = resp_err_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_op_o   = op_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with ALU_LAT=1 and a clocked behavioural ALU.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [1:0]  resp_z;
    logic        resp_err;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [2:0]  alu_op_o;
    logic [15:0] alu_result;
    logic [1:0]  alu_z;
    logic [15:0] done_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_done;
    logic [15:0] exp_in1;
    logic [15:0] exp_in2;
    logic [2:0]  exp_op;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic [1:0]  exp_z;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    always #5 clock = ~clock;

    alu_issue_ctrl #(
        .DATA_W  (16),
        .OP_W    (3),
        .ALU_LAT (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_z     (resp_z),
        .resp_err   (resp_err),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op_o   (alu_op_o),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .done_count (done_count)
    );

    // Behavioural ALU, one clock of latency: z[0] flags a zero result.
    logic [15:0] model_r;
    always_comb begin
        case (alu_op_o)
            3'd0:    model_r = alu_in1 + alu_in2;
            3'd1:    model_r = alu_in1 - alu_in2;
            3'd2:    model_r = alu_in1 & alu_in2;
            default: model_r = alu_in1 | alu_in2;
        endcase
    end
    always_ff @(posedge clock) begin
        alu_result <= model_r;
        alu_z      <= {1'b0, model_r == 16'd0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Returns the cycle number (accept edge ends cycle 0) in which resp_valid is first high, 0 on timeout.
    task automatic wait_resp(output int cyc);
        int n = 1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                cyc = n;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        req_op    = 3'd6;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        resp_ready = 1'b1;  // high before resp_valid; must not matter
        issue(v.op, v.a, v.b);
        if (!v.exp_err) begin
            exp_in1 = v.a;
            exp_in2 = v.b;
            exp_op  = v.op;
        end
        wait_resp(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        check({tag, "_data"}, 32'(resp_data), 32'(v.exp_data));
        check({tag, "_z"}, 32'(resp_z), 32'(v.exp_z));
        check({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
        check({tag, "_alu_in1"}, 32'(alu_in1), 32'(exp_in1));
        check({tag, "_alu_in2"}, 32'(alu_in2), 32'(exp_in2));
        check({tag, "_alu_op"}, 32'(alu_op_o), 32'(exp_op));
        check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
        step();
        exp_done++;
        resp_ready = 1'b0;
        check({tag, "_req_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid_after"}, 32'(resp_valid), 32'd0);
        check({tag, "_done_count"}, 32'(done_count), 32'(exp_done));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        check({tag, "_resp_z"}, 32'(resp_z), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_alu_in1"}, 32'(alu_in1), 32'd0);
        check({tag, "_alu_in2"}, 32'(alu_in2), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op_o), 32'd0);
        check({tag, "_done_count"}, 32'(done_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vecs[0] = '{3'd0, 16'd1,     16'd2,     16'd3,     2'b00, 1'b0, 3};
        vecs[1] = '{3'd5, 16'd4,     16'd4,     16'd0,     2'b00, 1'b1, 1};
        vecs[2] = '{3'd1, 16'd1,     16'd1,     16'd0,     2'b01, 1'b0, 3};
        vecs[3] = '{3'd2, 16'hF0F0,  16'h0FF0,  16'h00F0,  2'b00, 1'b0, 3};
        vecs[4] = '{3'd3, 16'h1200,  16'h0034,  16'h1234,  2'b00, 1'b0, 3};
        vecs[5] = '{3'd0, 16'hFFFF,  16'h0001,  16'h0000,  2'b01, 1'b0, 3};
        vecs[6] = '{3'd7, 16'h5555,  16'hAAAA,  16'h0000,  2'b00, 1'b1, 1};
        vecs[7] = '{3'd1, 16'h0000,  16'h0001,  16'hFFFF,  2'b00, 1'b0, 3};
        vecs[8] = '{3'd4, 16'h0001,  16'h0001,  16'h0000,  2'b00, 1'b1, 1};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        exp_done   = '0;
        exp_in1    = '0;
        exp_in2    = '0;
        exp_op     = '0;
        step();
        step();
        check_reset_values("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Back-pressure: result held stable while the consumer stalls.
        issue(3'd1, 16'd10, 16'd3);
        wait_resp(cyc);
        check("bp_latency", 32'(cyc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data", 32'(resp_data), 32'd7);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        exp_done++;
        check("bp_req_ready_after", 32'(req_ready), 32'd1);
        check("bp_done_count", 32'(done_count), 32'(exp_done));

        // Request held during RESP is ignored; the values present at the accept edge win.
        issue(3'd0, 16'd5, 16'd6);
        wait_resp(cyc);
        check("ign_first_data", 32'(resp_data), 32'd11);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'd100;
        req_b     = 16'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ign_req_ready", 32'(req_ready), 32'd0);
            check("ign_data_held", 32'(resp_data), 32'd11);
            check("ign_alu_in1_held", 32'(alu_in1), 32'd5);
        end
        req_a      = 16'd7;
        req_b      = 16'd8;
        resp_ready = 1'b1;
        step();  // handshake edge, request still ignored
        resp_ready = 1'b0;
        exp_done++;
        check("ign_idle_ready", 32'(req_ready), 32'd1);
        check("ign_alu_in1_not_taken", 32'(alu_in1), 32'd5);
        step();  // accept edge
        req_valid = 1'b0;
        req_a     = 16'hDEAD;
        check("ign_accepted_in1", 32'(alu_in1), 32'd7);
        check("ign_accepted_in2", 32'(alu_in2), 32'd8);
        wait_resp(cyc);
        check("ign_second_data", 32'(resp_data), 32'd15);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        exp_done++;
        check("ign_done_count", 32'(done_count), 32'(exp_done));

        // Reset in the middle of WAIT drops the op.
        issue(3'd0, 16'd20, 16'd100);
        check("rst_in_wait_in1", 32'(alu_in1), 32'd20);
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        step();
        step();
        check_reset_values("rst_held");
        reset_n  = 1'b1;
        exp_done = '0;
        exp_in1  = '0;
        exp_in2  = '0;
        exp_op   = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        begin
            vec_t v;
            v = '{3'd0, 16'd1, 16'd1, 16'd2, 2'b00, 1'b0, 3};
            run_vec(v, 100);
        end

        // done_count wrap.
        force dut.done_q = 16'hFFFF;
        #1;
        release dut.done_q;
        #1;
        check("wrap_preset", 32'(done_count), 32'h0000FFFF);
        exp_done = 16'hFFFF;
        begin
            vec_t v;
            v = '{3'd0, 16'd2, 16'd3, 16'd5, 2'b00, 1'b0, 3};
            run_vec(v, 101);
        end
        check("wrap_zero", 32'(done_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
